// File: rtl/rs232_tx_arbiter_if.sv
// Requester/serializer bundle for rs232_tx_arbiter: four byte producers on one side,
// the Rs232_tx load pair plus grant status on the other.
interface rs232_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  pi_data;
    logic        pi_flag;
    logic        busy;
    logic [1:0]  grant_id;

    modport master (
        output req,
        output req_data,
        input  ack,
        input  pi_data,
        input  pi_flag,
        input  busy,
        input  grant_id
    );

    modport slave (
        input  req,
        input  req_data,
        output ack,
        output pi_data,
        output pi_flag,
        output busy,
        output grant_id
    );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// Four-way arbiter feeding one Rs232_tx serializer; holds off for a frame plus guard after each grant.
// Define RS232_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round robin.
module rs232_tx_arbiter #(
    parameter int UART_BPS     = 9600,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    rs232_tx_arbiter_if.slave  bus
);
    localparam int BAUD_CNT     = CLK_FREQ / UART_BPS;
    localparam int FRAME_CYCLES = BAUD_CNT * 10;
    localparam int HOLD_CYCLES  = FRAME_CYCLES + GUARD_CYCLES;
    localparam int CNT_W        = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       pi_data_reg;
    logic             pi_flag_reg;
    logic [3:0]       ack_reg;
    logic             busy_reg;
    logic [1:0]       grant_id_reg;

    logic [7:0]       lane [4];
    logic [1:0]       winner;
    logic             any_req;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = bus.req_data[8*gi +: 8];
        end
    endgenerate

    assign any_req = |bus.req;

`ifdef RS232_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[k]) winner = 2'(k);
        end
    end
`else
    // ptr_reg is where the next search begins: one past the last winner, 0 after reset.
    logic [1:0] ptr_reg;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        winner = ptr_reg;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_reg + 2'(k);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 2'd0;
        end else if (state_reg == S_IDLE && any_req) begin
            ptr_reg <= winner + 2'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            pi_data_reg  <= 8'h00;
            pi_flag_reg  <= 1'b0;
            ack_reg      <= 4'b0000;
            busy_reg     <= 1'b0;
            grant_id_reg <= 2'd0;
        end else begin
            pi_flag_reg <= 1'b0;
            ack_reg     <= 4'b0000;
            case (state_reg)
                S_IDLE: begin
                    if (any_req) begin
                        pi_data_reg  <= lane[winner];
                        pi_flag_reg  <= 1'b1;
                        ack_reg      <= 4'b0001 << winner;
                        grant_id_reg <= winner;
                        busy_reg     <= 1'b1;
                        cnt_reg      <= '0;
                        state_reg    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Requests are deliberately ignored here; the serializer is mid-frame.
                    if (cnt_reg == CNT_LAST) begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.pi_data  = pi_data_reg;
    assign bus.pi_flag  = pi_flag_reg;
    assign bus.ack      = ack_reg;
    assign bus.busy     = busy_reg;
    assign bus.grant_id = grant_id_reg;
endmodule

// File: doc/rs232_tx_arbiter.md
# rs232_tx_arbiter

Shares one `Rs232_tx` serializer between four byte producers, such as a loopback echo path, a status reporter and debug taps. The block takes a byte from one requester at a time and drives it onto the serializer's `pi_data`/`pi_flag` pair. It then holds off further grants for a full UART frame plus a guard time, so the serializer is never re-triggered mid-frame. Requesters are chosen in round-robin order by default, or by fixed priority when the configuration macro is defined.

## Interface
Parameters:
- `UART_BPS`, 9600: line baud rate; must match the attached `Rs232_tx`.
- `CLK_FREQ`, 50_000_000: `clk` frequency in Hz.
- `GUARD_CYCLES`, 2: idle `clk` cycles added after each frame before the next grant.
- Derived, not overridable: `BAUD_CNT = CLK_FREQ/UART_BPS` (integer divide; 5208 at the defaults).
- Derived, not overridable: `FRAME_CYCLES = BAUD_CNT*10` (52080 at the defaults).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  4  `req[i]` high means requester i has a byte pending.
- `req_data`  in  32  byte for requester i on `req_data[8i+7:8i]`.
- `ack`  out  4  one-cycle pulse; the byte of requester i has been taken.
- `pi_data`  out  8  byte to `Rs232_tx`.
- `pi_flag`  out  1  one-cycle load strobe to `Rs232_tx`.
- `busy`  out  1  high from grant until the frame and guard time have elapsed.
- `grant_id`  out  2  index of the most recent grant.

## Operation
- The FSM has two states: IDLE and WAIT. All outputs are registered.
- IDLE with any `req` bit high at a `clk` edge, in the same edge:
  - select a winner;
  - `pi_data <= req_data[winner]`, `pi_flag <= 1`, `ack[winner] <= 1`;
  - `grant_id <= winner`, `busy <= 1`, `cnt <= 0`, next state WAIT.
- IDLE with no `req` bit high: stay in IDLE; `pi_flag` and `ack` stay 0.
- WAIT:
  - `pi_flag` and `ack` return to 0 after one cycle;
  - `cnt` increments every cycle;
  - at the edge where `cnt == FRAME_CYCLES+GUARD_CYCLES-1`, set `busy <= 0` and return to IDLE;
  - `req` is ignored while in WAIT.
- Counter width is `$clog2(FRAME_CYCLES+GUARD_CYCLES)`. `cnt` never wraps; it is cleared on every grant.
- Round-robin selection:
  - the search starts at `grant_id+1` (mod 4) and wraps 3→0;
  - the first set `req` bit wins;
  - after reset the search pointer is set so that requester 0 is searched first.
- Requester handshake:
  - hold `req[i]` and its data stable until `ack[i]` is seen;
  - to stop, drop `req[i]` in the cycle after `ack[i]`;
  - to send again, keep `req[i]` high and present the new byte in the cycle after `ack[i]`;
  - a request withdrawn before `ack[i]` is never granted and sends nothing.
- Reset, asserted at any time including mid-WAIT:
  - `pi_data = 0`, `pi_flag = 0`, `ack = 0`, `busy = 0`, `grant_id = 0`;
  - state returns to IDLE, `cnt = 0`, search pointer returns to requester 0;
  - any in-flight serializer frame is not tracked.

## Timing
- Grant latency is 1 cycle: `req` sampled high at edge N gives `pi_flag`/`ack` high in cycle N..N+1.
- `pi_flag` and `ack[winner]` are coincident, each exactly one cycle wide.
- `busy` is high for `FRAME_CYCLES+GUARD_CYCLES` cycles per grant (52082 at the defaults).
- Minimum spacing between consecutive `pi_flag` pulses is `FRAME_CYCLES+GUARD_CYCLES+1` cycles (52083 at the defaults).
- Simultaneous requests produce exactly one grant per IDLE cycle; `ack` is always one-hot or zero.

## Configuration
- `RS232_ARB_FIXED_PRIO_EN` defined: fixed priority; the lowest set `req` index wins every time. A continuously requesting low index can starve higher indices.
- `RS232_ARB_FIXED_PRIO_EN` undefined (default): round robin as described above.

## Test plan
All scenarios use the defaults: 50 MHz `clk`, `UART_BPS` 9600, `GUARD_CYCLES` 2.
- Reset check: hold `rst` high with random `req`/`req_data` -> `pi_flag = 0`, `ack = 0`, `busy = 0`, `grant_id = 0`, `pi_data = 8'h00`.
- Single request: `req = 4'b0100`, byte 2 = `8'hA5` -> one cycle later `pi_data = 8'hA5`, `pi_flag = 1`, `ack = 4'b0100`, `grant_id = 2`; `busy` stays high for 52082 cycles.
- Round robin: `req = 4'hF` held, bytes `8'h10`/`8'h11`/`8'h12`/`8'h13` -> grant order 0,1,2,3,0; `pi_data` sequence `8'h10`,`8'h11`,`8'h12`,`8'h13`,`8'h10`; `pi_flag` spacing exactly 52083 cycles.
- Fixed priority (`RS232_ARB_FIXED_PRIO_EN` defined): `req = 4'b1001` held -> every grant goes to requester 0; `ack[3]` never pulses.
- Withdrawn request: `req[1]` raised during WAIT, then dropped before `busy` falls -> no `ack[1]` pulse and no extra `pi_flag`.
- Reset mid-frame: assert `rst` 1000 cycles into WAIT, release, then hold `req = 4'b1010` -> `busy` is 0 during reset; first grant after release is requester 1, the next is requester 3.
